pixel_packer: RTL and testbench

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/pixel_packer_pkg.sv | 20 ++
 rtl/pixel_packer_sync_fifo.sv | 70 +++++++
 rtl/pixel_packer.sv | 111 +++++++++++
 tb/tb_pixel_packer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pixel_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_packer_pkg : geometry and pixel width shared with the Mandelbrot core |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package pixel_packer_pkg;

  localparam int MANDEL_LINE_W = 640;
  localparam int MANDEL_LINES  = 480;
  localparam int PIX_W         = 4;

  // One FIFO entry: two packed pixels plus frame/line markers.
  typedef struct packed {
    logic               eol;
    logic               sof;
    logic [2*PIX_W-1:0] data;
  } pkt_t;

endpackage
`default_nettype wire

// File: rtl/pixel_packer_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with occupancy counter, drop-on-full         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         almost_full,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_AF   = (AW+1)'(DEPTH - 2);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;
  logic          w_full;

  assign rd_valid    = (r_count != '0);
  assign almost_full = (r_count >= c_AF);
  assign w_full      = (r_count == c_FULL);
  assign w_pop       = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push      = wr_en && (!w_full || w_pop);
  assign drop        = wr_en && w_full && !w_pop;
  assign rd_data     = rd_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_packer : packs 4-bit iteration counts into bytes with sof/eol marks  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int LINE_W     = MANDEL_LINE_W,
  parameter int LINES      = MANDEL_LINES,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eol,
  output logic             almost_full,
  output logic             overflow,
  output logic             frame_done
);

  localparam int XW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int YW = (LINES  > 1) ? $clog2(LINES)  : 1;
  localparam logic [XW-1:0] c_X_LAST = XW'(LINE_W - 1);
  localparam logic [YW-1:0] c_Y_LAST = YW'(LINES - 1);

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic             r_phase;
  logic [PIX_W-1:0] r_held;
  logic             r_overflow;
  logic             r_frame_done;

  logic             w_x_last;
  logic             w_y_last;
  logic             w_push;
  logic             w_drop;
  pkt_t             w_wr_pkt;
  pkt_t             w_rd_pkt;

  assign w_x_last = (r_x == c_X_LAST);
  assign w_y_last = (r_y == c_Y_LAST);
  assign w_push   = in_valid && r_phase && !clear;

  // Second pixel of the pair is in_pixel, so it lands in the upper nibble.
  assign w_wr_pkt.data = {in_pixel, r_held};
  assign w_wr_pkt.sof  = (r_x == XW'(1)) && (r_y == '0);
  assign w_wr_pkt.eol  = w_x_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_phase      <= 1'b0;
      r_held       <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (clear) begin
      r_x          <= '0;
      r_y          <= '0;
      r_phase      <= 1'b0;
      r_held       <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      if (in_valid) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_held <= in_pixel;
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
        r_frame_done <= r_phase && w_x_last && w_y_last;
      end
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(pkt_t))
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .wr_en       (w_push),
    .wr_data     (w_wr_pkt),
    .rd_ready    (out_ready),
    .rd_data     (w_rd_pkt),
    .rd_valid    (out_valid),
    .almost_full (almost_full),
    .drop        (w_drop)
  );

  assign out_data   = w_rd_pkt.data;
  assign out_sof    = w_rd_pkt.sof;
  assign out_eol    = w_rd_pkt.eol;
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_packer.sv
`default_nettype none
// Bench for pixel_packer: two geometries driven in lockstep, checked against
// a pixel-index / scoreboard model of the packing rules.
module tb_pixel_packer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_pixel = 4'h0;
  logic       out_ready = 1'b0;

  logic [7:0] od [2];
  logic       ov [2], osof [2], oeol [2], oaf [2], oovf [2], ofd [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pixel_packer #(.LINE_W(8), .LINES(2), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_pixel(in_pixel),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_sof(osof[0]),
    .out_eol(oeol[0]), .almost_full(oaf[0]), .overflow(oovf[0]), .frame_done(ofd[0])
  );

  pixel_packer #(.LINE_W(4), .LINES(2), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_pixel(in_pixel),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_sof(osof[1]),
    .out_eol(oeol[1]), .almost_full(oaf[1]), .overflow(oovf[1]), .frame_done(ofd[1])
  );

  // Reference model: pixel index within the frame plus an expected-byte log.
  int         mlw [2];
  int         mln [2];
  int         midx [2];
  logic [3:0] mheld [2];
  bit         movf [2];
  bit         mfd [2];
  logic [9:0] mbuf [2][4096];
  int         mhead [2];
  int         mtail [2];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      midx[k] = 0; mheld[k] = 4'h0; movf[k] = 0; mfd[k] = 0;
      mhead[k] = mtail[k];
    end
  endtask

  task automatic model_edge(input logic v, input logic [3:0] p, input logic r, input logic c);
    for (int k = 0; k < 2; k++) begin
      mfd[k] = 0;
      if (c) begin
        mhead[k] = mtail[k];
        midx[k] = 0; mheld[k] = 4'h0; movf[k] = 0;
      end else begin
        if (r && (mtail[k] > mhead[k])) mhead[k]++;
        if (v) begin
          if (midx[k] % 2 == 1) begin
            if (mtail[k] - mhead[k] < DEPTH) begin
              mbuf[k][mtail[k]] = {((midx[k] % mlw[k]) == mlw[k] - 1), (midx[k] == 1), p, mheld[k]};
              mtail[k]++;
            end else begin
              movf[k] = 1;
            end
            if (midx[k] == mlw[k] * mln[k] - 1) mfd[k] = 1;
          end else begin
            mheld[k] = p;
          end
          midx[k] = (midx[k] + 1) % (mlw[k] * mln[k]);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int occ;
      logic [9:0] e;
      occ = mtail[k] - mhead[k];
      e = (occ > 0) ? mbuf[k][mhead[k]] : 10'h0;
      chk("out_valid", k, 32'(ov[k]), 32'(occ > 0));
      chk("out_data", k, 32'(od[k]), 32'(e[7:0]));
      chk("out_sof", k, 32'(osof[k]), 32'(e[8]));
      chk("out_eol", k, 32'(oeol[k]), 32'(e[9]));
      chk("almost_full", k, 32'(oaf[k]), 32'(occ >= DEPTH - 2));
      chk("overflow", k, 32'(oovf[k]), 32'(movf[k]));
      chk("frame_done", k, 32'(ofd[k]), 32'(mfd[k]));
    end
  endtask

  task automatic step(input logic v, input logic [3:0] p, input logic r, input logic c);
    in_valid = v; in_pixel = p; out_ready = r; clear = c;
    model_edge(v, p, r, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  int fdcnt;

  initial begin
    mlw[0] = 8; mln[0] = 2; mlw[1] = 4; mln[1] = 2;
    mhead[0] = 0; mtail[0] = 0; mhead[1] = 0; mtail[1] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Pixels 3 then 12 with the consumer ready.
    step(1, 4'd3, 1, 0);
    step(1, 4'd12, 1, 0);
    chk("first_byte", 0, 32'(od[0]), 32'h0000_00C3);
    chk("first_sof", 0, 32'(osof[0]), 32'h1);

    // Rest of an 8-pixel line: eol only on the 4th byte.
    for (int i = 0; i < 6; i++) step(1, 4'(i + 4), 1, 0);
    step(0, 4'h0, 1, 0);

    // Back-pressure: 18 pixels into a stalled FIFO.
    step(0, 4'h0, 1, 1);
    for (int i = 0; i < 2 * DEPTH + 2; i++) step(1, 4'($urandom_range(0, 15)), 0, 0);
    chk("ovf_after_fill", 0, 32'(oovf[0]), 32'h1);
    chk("af_after_fill", 1, 32'(oaf[1]), 32'h1);

    // Asynchronous reset mid-frame with a held nibble and a full FIFO.
    step(1, 4'h9, 0, 0);
    #3 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(ov[k]), 32'h0);
      chk("rst_data", k, 32'(od[k]), 32'h0);
      chk("rst_ovf", k, 32'(oovf[k] | osof[k] | oeol[k] | oaf[k] | ofd[k]), 32'h0);
    end
    in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    step(1, 4'h5, 1, 0);
    step(1, 4'h6, 1, 0);
    chk("post_rst_byte", 0, 32'(od[0]), 32'h0000_0065);

    // Exactly full, then push coinciding with pop: no overflow.
    step(0, 4'h0, 0, 1);
    for (int i = 0; i < 2 * DEPTH; i++) step(1, 4'($urandom_range(0, 15)), 0, 0);
    for (int i = 0; i < 6; i++) step(1, 4'($urandom_range(0, 15)), 1, 0);
    chk("no_ovf_pushpop", 0, 32'(oovf[0]), 32'h0);

    // Short frame on dut1: one frame_done pulse, then sof again.
    step(0, 4'h0, 1, 1);
    fdcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 4'(i), 1, 0);
      fdcnt += int'(ofd[1]);
    end
    step(1, 4'hA, 1, 0);
    fdcnt += int'(ofd[1]);
    step(1, 4'hB, 1, 0);
    chk("fd_once", 1, 32'(fdcnt), 32'h1);
    chk("sof_again", 1, 32'(osof[1]), 32'h1);

    // Clear discards a half-packed pixel.
    step(0, 4'h0, 1, 1);
    step(1, 4'hF, 1, 0);
    step(1, 4'h7, 1, 1);
    step(1, 4'h1, 1, 0);
    step(1, 4'h2, 1, 0);
    chk("clear_byte", 1, 32'(od[1]), 32'h0000_0021);
    chk("clear_sof", 1, 32'(osof[1]), 32'h1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
